// File: rtl/add_pkg.sv
// Shared constants for the pipelined three-operand adder and its final CLA.
package add_pkg;
  localparam int ADD_DEFAULT_WIDTH = 8;
  localparam int ADD_CLA_GROUP     = 4;
  localparam int ADD_LATENCY       = 2;

  function automatic int cla_num_groups(input int n);
    return (n + ADD_CLA_GROUP - 1) / ADD_CLA_GROUP;
  endfunction
endpackage

// File: rtl/pipelined_adder_3_nbits_cla.sv
// Combinational carry-lookahead adder: lookahead inside each 4-bit group and
// across group generate/propagate terms, so no carry ripples between groups.
module cla_adder_nbits
  import add_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  localparam int GS = ADD_CLA_GROUP;
  localparam int NG = cla_num_groups(N);
  localparam int NP = NG * GS;

  logic [NP-1:0] a_pad, b_pad, g, p;
  logic [NP:0]   c;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   cg;
  logic [NP:0]   s_full;
  logic          unused_hi;

  assign a_pad = NP'(a_i);
  assign b_pad = NP'(b_i);
  assign g     = a_pad & b_pad;
  assign p     = a_pad ^ b_pad;

  always_comb begin
    logic acc;
    logic prop;
    acc  = 1'b0;
    prop = 1'b1;
    gg   = '0;
    gp   = '0;
    cg   = '0;
    c    = '0;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[j*GS +: GS];
      acc   = 1'b0;
      prop  = 1'b1;
      for (int k = GS - 1; k >= 0; k--) begin
        acc  = acc | (prop & g[j*GS+k]);
        prop = prop & p[j*GS+k];
      end
      gg[j] = acc;
    end
    // Group carries are flattened sums of products over gg/gp and cin.
    cg[0] = cin_i;
    for (int j = 1; j <= NG; j++) begin
      acc  = 1'b0;
      prop = 1'b1;
      for (int k = j - 1; k >= 0; k--) begin
        acc  = acc | (prop & gg[k]);
        prop = prop & gp[k];
      end
      cg[j] = acc | (prop & cin_i);
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GS; i++) begin
        acc  = 1'b0;
        prop = 1'b1;
        for (int k = i - 1; k >= 0; k--) begin
          acc  = acc | (prop & g[j*GS+k]);
          prop = prop & p[j*GS+k];
        end
        c[j*GS+i] = acc | (prop & cg[j]);
      end
    end
    c[NP] = cg[NG];
  end

  assign s_full    = {c[NP], p ^ c[NP-1:0]};
  assign sum_o     = s_full[N-1:0];
  assign cout_o    = s_full[N];
  assign unused_hi = ^s_full[NP:N];
endmodule

// File: rtl/pipelined_adder_3_nbits.sv
// Two-stage valid/ready adder of three operands plus carry-in: S1 holds the
// 3:2 compressed vectors, S2 holds the CLA result that drives the outputs.
module pipelined_adder_3_nbits
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout_1,
  output logic             cout_2
);
  localparam int N = WIDTH + 1;

  logic             adv1, adv2;
  logic             s1_valid_q, s2_valid_q;
  logic [N-1:0]     s1_ps_q, s1_ps_d, s1_cy_q, s1_cy_d;
  logic             s1_cin_q;
  logic [WIDTH+1:0] s2_res_q, s2_res_d;

  assign adv2     = !s2_valid_q | out_ready;
  assign adv1     = !s1_valid_q | adv2;
  assign in_ready = adv1;

  // Carry-save form: ps + cy + cin equals in1 + in2 + in3 + cin.
  assign s1_ps_d = {1'b0, in1 ^ in2 ^ in3};
  assign s1_cy_d = {(in1 & in2) | (in1 & in3) | (in2 & in3), 1'b0};

  cla_adder_nbits #(.N(N)) u_cla (
    .a_i   (s1_ps_q),
    .b_i   (s1_cy_q),
    .cin_i (s1_cin_q),
    .sum_o (s2_res_d[N-1:0]),
    .cout_o(s2_res_d[N])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_ps_q    <= '0;
      s1_cy_q    <= '0;
      s1_cin_q   <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
        s1_ps_q    <= s1_ps_d;
        s1_cy_q    <= s1_cy_d;
        s1_cin_q   <= cin;
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        s2_res_q   <= s2_res_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = s2_res_q[WIDTH-1:0];
  assign cout_1    = s2_res_q[WIDTH];
  assign cout_2    = s2_res_q[WIDTH+1];
endmodule

// File: tb/tb_pipelined_adder_3_nbits.sv
// Bench for pipelined_adder_3_nbits: directed table and stall/reset sequences
// at WIDTH=8, plus random valid/ready traffic at WIDTH=32 and WIDTH=5.
module tb_pipelined_adder_3_nbits;
  import add_pkg::*;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout_1, cout_2;
  logic [W-1:0] in1, in2, in3, sum;

  pipelined_adder_3_nbits #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .in3(in3), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout_1(cout_1), .cout_2(cout_2)
  );

  typedef struct {
    logic [W-1:0] a, b, c;
    logic         ci;
    logic [W+1:0] r;
  } vec_t;

  vec_t         vt[10];
  vec_t         sv[6];
  logic [W+1:0] exp_q[$];
  int           acc_cyc_q[$];
  int           cyc = 0;
  int           n_pass = 0, n_tot = 0, n_out = 0;
  bit           chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, b, c, input logic ci);
    return {2'b00, a} + {2'b00, b} + {2'b00, c} + {{(W+1){1'b0}}, ci};
  endfunction

  // Scoreboard consumer for the WIDTH=8 instance.
  initial begin
    logic [W+1:0] r;
    int           a;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL spurious_result: got %0h with nothing expected", {cout_2, cout_1, sum});
        end else begin
          r = exp_q.pop_front();
          a = acc_cyc_q.pop_front();
          check("result", {cout_2, cout_1, sum}, r);
          if (chk_lat) check("latency", cyc - a, ADD_LATENCY);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v, input bit must_ready);
    bit accepted;
    accepted = 1'b0;
    in1 = v.a; in2 = v.b; in3 = v.c; cin = v.ci; in_valid = 1'b1;
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      if (must_ready && t == 0) check("in_ready_high", in_ready, 1);
      if (in_ready) begin
        exp_q.push_back(v.r);
        acc_cyc_q.push_back(cyc);
        accepted = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!accepted) begin
      n_tot++;
      $display("FAIL accept_timeout: got no in_ready in 50 cycles expected acceptance");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Random valid/ready traffic at two further widths, each with its own scoreboard.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
    localparam int RW = (gi == 0) ? 32 : 5;
    localparam int NV = 10000;
    typedef logic [RW+1:0] r_t;
    logic          r_rst, r_iv, r_ir, r_ci, r_ov, r_or, r_c1, r_c2;
    logic [RW-1:0] r_a, r_b, r_c, r_s;
    r_t            q[$];
    int            pass = 0, tot = 0;
    bit            done = 1'b0;

    pipelined_adder_3_nbits #(.WIDTH(RW)) dut_r (
      .clk(clk), .rst(r_rst), .in_valid(r_iv), .in_ready(r_ir),
      .in1(r_a), .in2(r_b), .in3(r_c), .cin(r_ci),
      .out_valid(r_ov), .out_ready(r_or),
      .sum(r_s), .cout_1(r_c1), .cout_2(r_c2)
    );

    initial begin
      int sent, got, cycles;
      r_t e;
      sent = 0; got = 0; cycles = 0;
      r_rst = 1'b1; r_iv = 1'b0; r_or = 1'b0; r_ci = 1'b0;
      r_a = '0; r_b = '0; r_c = '0;
      repeat (2) @(posedge clk);
      #1 r_rst = 1'b0;
      while (got < NV && cycles < 60000) begin
        r_iv = (sent < NV) && ($urandom_range(3) != 0);
        r_a  = RW'($urandom());
        r_b  = RW'($urandom());
        r_c  = RW'($urandom());
        r_ci = 1'($urandom());
        r_or = ($urandom_range(3) != 0);
        @(negedge clk);
        if (r_iv && r_ir) begin
          q.push_back(r_t'(r_a) + r_t'(r_b) + r_t'(r_c) + r_t'(r_ci));
          sent++;
        end
        if (r_ov && r_or) begin
          tot++;
          got++;
          if (q.size() == 0) begin
            $display("FAIL rnd_w%0d_spurious: got %0h with nothing expected", RW, {r_c2, r_c1, r_s});
          end else begin
            e = q.pop_front();
            if ({r_c2, r_c1, r_s} === e) pass++;
            else $display("FAIL rnd_w%0d_result: got %0h expected %0h", RW, {r_c2, r_c1, r_s}, e);
          end
        end
        @(posedge clk); #1;
        cycles++;
      end
      tot++;
      if (got == NV && q.size() == 0) pass++;
      else $display("FAIL rnd_w%0d_count: got %0d results (%0d pending) expected %0d", RW, got, q.size(), NV);
      done = 1'b1;
    end
  end

  initial begin
    int idx, out_before, t;

    vt[0] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 10'h2FE};
    vt[1] = '{8'h00, 8'h00, 8'h00, 1'b0, 10'h000};
    vt[2] = '{8'h80, 8'h80, 8'h00, 1'b0, 10'h100};
    vt[3] = '{8'h01, 8'h02, 8'h03, 1'b1, 10'h007};
    vt[4] = '{8'hFF, 8'h00, 8'h00, 1'b1, 10'h100};
    vt[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 10'h1FE};
    vt[6] = '{8'h12, 8'h34, 8'h56, 1'b1, 10'h09D};
    vt[7] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 10'h1FE};
    vt[8] = '{8'h7F, 8'h7F, 8'h7F, 1'b1, 10'h17E};
    vt[9] = '{8'h0F, 8'hF0, 8'h33, 1'b0, 10'h132};
    for (int i = 0; i < 6; i++) begin
      sv[i].a  = 8'($urandom());
      sv[i].b  = 8'($urandom());
      sv[i].c  = 8'($urandom());
      sv[i].ci = 1'($urandom());
      sv[i].r  = model(sv[i].a, sv[i].b, sv[i].c, sv[i].ci);
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; in3 = '0; cin = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", {cout_2, cout_1, sum}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table, back to back with the consumer always ready.
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++) send(vt[i], 1'b1);
    in_valid = 1'b0;
    drain();
    check("b2b_count", n_out, 10);

    // Consumer stalls while the producer keeps offering data.
    chk_lat = 1'b0;
    out_before = n_out;
    out_ready = 1'b0;
    idx = 0;
    in1 = sv[0].a; in2 = sv[0].b; in3 = sv[0].c; cin = sv[0].ci; in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(sv[idx].r);
        acc_cyc_q.push_back(cyc);
        idx++;
      end
      @(posedge clk); #1;
      in1 = sv[idx].a; in2 = sv[idx].b; in3 = sv[idx].c; cin = sv[idx].ci;
    end
    check("stall_accepts", idx, 2);
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_held_result", {cout_2, cout_1, sum}, sv[0].r);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = idx; i < 6; i++) send(sv[i], 1'b1);
    in_valid = 1'b0;
    drain();
    check("stall_count", n_out - out_before, 6);

    // Reset with both stages full discards the in-flight work.
    out_ready = 1'b0;
    send(vt[3], 1'b1);
    send(vt[8], 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_result", {cout_2, cout_1, sum}, 0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete();
    acc_cyc_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_lat = 1'b1;
    out_before = n_out;
    send(vt[6], 1'b1);
    in_valid = 1'b0;
    drain();
    check("post_rst_count", n_out - out_before, 1);

    t = 0;
    while (!(g_rnd[0].done && g_rnd[1].done) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    check("rnd_finished", {g_rnd[0].done, g_rnd[1].done}, 2'b11);

    n_pass += g_rnd[0].pass + g_rnd[1].pass;
    n_tot  += g_rnd[0].tot + g_rnd[1].tot;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/pipelined_adder_3_nbits.md
PIPELINED_ADDER_3_NBITS -- requirements
Module: pipelined_adder_3_nbits

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..64.
REQ-002 SHALL have clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have in_valid, input, 1, operand set present.
REQ-005 SHALL have in_ready, output, 1, block accepts operands this cycle.
REQ-006 SHALL have in1, in2, in3, input, WIDTH each, unsigned addends.
REQ-007 SHALL have cin, input, 1, carry-in.
REQ-008 SHALL have out_valid, output, 1, result present.
REQ-009 SHALL have out_ready, input, 1, consumer takes result this cycle.
REQ-010 SHALL have sum, output, WIDTH, result bits [WIDTH-1:0].
REQ-011 SHALL have cout_1, cout_2, output, 1 each, result bits WIDTH and WIDTH+1.

Function
REQ-012 SHALL compute R = in1 + in2 + in3 + cin exactly, as a WIDTH+2-bit unsigned value; no truncation, no overflow possible.
REQ-013 SHALL map {cout_2, cout_1, sum} = R.
REQ-014 SHALL use two register stages: S1 holds per-bit 3:2 compressed partial sum and shifted carry vectors (WIDTH+1 bits each) plus cin; S2 holds the final carry-lookahead sum (output register).
REQ-015 S2 final adder SHALL be carry-lookahead with 4-bit groups and group-level lookahead; no ripple across groups.
REQ-016 Transfer on a port SHALL occur only in a cycle where valid and ready are both high.
REQ-017 adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready SHALL equal adv1 (combinational path out_ready -> in_ready permitted).
REQ-018 S1 SHALL load when adv1; s1_valid <= in_valid. S2 SHALL load from S1 when adv2; s2_valid <= s1_valid.
REQ-019 Latency SHALL be 2 cycles: operands accepted at edge k give out_valid high after edge k+1 with no stall; throughput 1 result per cycle.
REQ-020 While out_valid & !out_ready, sum/cout_1/cout_2 SHALL hold stable and no result SHALL be dropped or duplicated.
REQ-021 Capacity SHALL be 2 in-flight results; with out_ready low and both stages full, in_ready SHALL be low.
REQ-022 Simultaneous out handshake and in handshake with both stages full SHALL advance the whole pipeline in the same cycle.
REQ-023 Results SHALL emerge in acceptance order.
REQ-024 Data registers of invalid stages are don't-care but SHALL NOT be presented with out_valid high.

Reset
REQ-025 On rst high, s1_valid and s2_valid SHALL clear to 0 immediately (asynchronously); out_valid = 0.
REQ-026 On reset, sum, cout_1, cout_2 SHALL be 0; in-flight operations SHALL be discarded.
REQ-027 in_ready SHALL be 1 while rst is high; first acceptance occurs at the first rising edge after rst deasserts.

Structure
REQ-028 Shared package add_pkg SHALL hold ADD_DEFAULT_WIDTH (8), ADD_CLA_GROUP (4), ADD_LATENCY (2).
REQ-029 One sub-module cla_adder_nbits (parametrised width, combinational, group CLA) SHALL implement the S2 final addition; compression and pipeline control stay in the top.

Verification
REQ-030 WIDTH=8, in1=in2=in3=0xFF, cin=1, out_ready=1 -> two cycles later sum=0xFE, cout_1=0, cout_2=1 (766).
REQ-031 WIDTH=8, all zero, cin=0 -> sum=0x00, cout_1=0, cout_2=0; in1=0x80,in2=0x80,in3=0x00,cin=0 -> sum=0x00, cout_1=1, cout_2=0.
REQ-032 10 back-to-back transactions, out_ready=1 -> in_ready stays 1, 10 results on 10 consecutive cycles starting 2 cycles after first accept, in order.
REQ-033 out_ready=0 for 6 cycles while in_valid=1 -> exactly 2 accepted, then in_ready=0, sum stable; release -> results in order, none lost/duplicated.
REQ-034 rst pulsed with both stages full -> out_valid=0 and outputs 0 before next edge; post-reset transaction yields correct result with latency 2.
REQ-035 WIDTH=32 and WIDTH=5 random 10k vectors with random valid/ready -> every result matches reference sum R.
